// File: rtl/trig_pkg.sv
// Shared types and sizing helpers for the two-fold coincidence trigger.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

  // Bits needed to hold the largest of three clock counts (minimum 1 bit).
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// Per-channel input synchroniser, rising-edge detector and coincidence window.
module trig_edge_sync
  import trig_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WINDOW_CLKS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic win_clr_i,
  output logic rise_o,
  output logic open_o
);

  localparam int unsigned WIN_W = timer_width(WINDOW_CLKS, 0, 0);
  // The rise cycle itself counts as the first open cycle, so the counter only
  // has to cover the remaining WINDOW_CLKS-1 cycles; this gives the
  // |d1-d0| < WINDOW_CLKS acceptance rule.
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CLKS - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic             prev_q;
  logic [WIN_W-1:0] win_q;

  // Metastability synchroniser chain, shifting toward the MSB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Window countdown: clear from the FSM wins, a rise reloads (never extends).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               win_q <= '0;
    else if (win_clr_i)      win_q <= '0;
    else if (rise_o)         win_q <= WIN_LOAD;
    else if (win_q != '0)    win_q <= win_q - WIN_W'(1);
  end

  assign open_o = rise_o | (win_q != '0);

endmodule

// File: rtl/trig_coincidence.sv
// Registered two-fold coincidence trigger with fixed pulse, dead time and
// saturating single/coincidence rate counters, clk25 domain.
module trig_coincidence
  import trig_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WINDOW_CLKS  = 4,
  parameter int unsigned PULSE_CLKS   = 8,
  parameter int unsigned HOLDOFF_CLKS = 25,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig0_i,
  input  logic                 trig1_i,
  input  logic                 en_i,
  input  logic                 count_clr_i,
  output logic                 trig_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] trig0_count_o,
  output logic [CNT_WIDTH-1:0] trig1_count_o,
  output logic [CNT_WIDTH-1:0] coinc_count_o
);

  localparam int unsigned TMR_W = timer_width(PULSE_CLKS, HOLDOFF_CLKS, WINDOW_CLKS);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CLKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = (HOLDOFF_CLKS > 0) ? TMR_W'(HOLDOFF_CLKS - 1) : '0;

  logic rise0, open0, rise1, open1;
  logic win_clr;
  logic coinc;
  logic fire_start;

  trig_state_t      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             trig_q, busy_q;

  logic [CNT_WIDTH-1:0] trig0_cnt_q, trig1_cnt_q, coinc_cnt_q;

  trig_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WINDOW_CLKS (WINDOW_CLKS)
  ) u_ch0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .d_i       (trig0_i),
    .win_clr_i (win_clr),
    .rise_o    (rise0),
    .open_o    (open0)
  );

  trig_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WINDOW_CLKS (WINDOW_CLKS)
  ) u_ch1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .d_i       (trig1_i),
    .win_clr_i (win_clr),
    .rise_o    (rise1),
    .open_o    (open1)
  );

  assign coinc = open0 & open1 & (rise0 | rise1);

  // Next-state, shared pulse/holdoff timer and window clear.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    win_clr    = 1'b0;
    fire_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && coinc) begin
          state_d    = FIRE;
          tmr_d      = PULSE_LOAD;
          win_clr    = 1'b1;
          fire_start = 1'b1;
        end
      end
      FIRE: begin
        if (tmr_q == '0) begin
          if (HOLDOFF_CLKS == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            tmr_d   = HOLD_LOAD;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      HOLDOFF: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // State, timer and glitch-free registered outputs decoded from next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      trig_q  <= (state_d == FIRE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Channel 0 single-rate counter, saturating, clear has priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              trig0_cnt_q <= '0;
    else if (count_clr_i)                   trig0_cnt_q <= '0;
    else if (rise0 && (trig0_cnt_q != '1))  trig0_cnt_q <= trig0_cnt_q + CNT_WIDTH'(1);
  end

  // Channel 1 single-rate counter, saturating, clear has priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              trig1_cnt_q <= '0;
    else if (count_clr_i)                   trig1_cnt_q <= '0;
    else if (rise1 && (trig1_cnt_q != '1))  trig1_cnt_q <= trig1_cnt_q + CNT_WIDTH'(1);
  end

  // Coincidence counter, bumped on each IDLE->FIRE transition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   coinc_cnt_q <= '0;
    else if (count_clr_i)                        coinc_cnt_q <= '0;
    else if (fire_start && (coinc_cnt_q != '1))  coinc_cnt_q <= coinc_cnt_q + CNT_WIDTH'(1);
  end

  assign trig_o        = trig_q;
  assign busy_o        = busy_q;
  assign trig0_count_o = trig0_cnt_q;
  assign trig1_count_o = trig1_cnt_q;
  assign coinc_count_o = coinc_cnt_q;

endmodule

// File: tb/tb_trig_coincidence.sv
// Directed self-checking bench for trig_coincidence at default parameters.
module tb_trig_coincidence;

  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] ALL = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          trig0, trig1, en, clr;
  logic          trig_o, busy_o;
  logic [CW-1:0] c0, c1, cc;

  int checks = 0;
  int errors = 0;
  int lat, hi, bz;

  trig_coincidence #(
    .SYNC_STAGES  (2),
    .WINDOW_CLKS  (4),
    .PULSE_CLKS   (8),
    .HOLDOFF_CLKS (25),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .trig0_i       (trig0),
    .trig1_i       (trig1),
    .en_i          (en),
    .count_clr_i   (clr),
    .trig_o        (trig_o),
    .busy_o        (busy_o),
    .trig0_count_o (c0),
    .trig1_count_o (c1),
    .coinc_count_o (cc)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input logic [CW-1:0] e0,
                            input logic [CW-1:0] e1, input logic [CW-1:0] ec);
    chk({tag, "_trig0_count"}, 64'(c0), 64'(e0));
    chk({tag, "_trig1_count"}, 64'(c1), 64'(e1));
    chk({tag, "_coinc_count"}, 64'(cc), 64'(ec));
  endtask

  // Ticks until trig_o is seen high; -1 if it never rises within maxc ticks.
  task automatic wait_trig(input int maxc, output int l);
    l = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (trig_o === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  // Called with trig_o just high; returns pulse width, leaves first low cycle.
  task automatic to_pulse_end(output int h);
    h = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trig_o !== 1'b1) break;
      h++;
    end
  endtask

  // Pulse width and total busy width, ending on the first idle cycle.
  task automatic run_pulse(output int h, output int b);
    to_pulse_end(h);
    b = h;
    for (int i = 0; i < 100; i++) begin
      if (busy_o !== 1'b1) break;
      b++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (busy_o === 1'b0) break;
      tick();
    end
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic set_both(input logic v);
    trig0 = v;
    trig1 = v;
  endtask

  initial begin
    rst = 1'b1; trig0 = 1'b0; trig1 = 1'b0; en = 1'b1; clr = 1'b0;
    ticks(3);
    chk("reset_trig", 64'(trig_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk_counts("reset", '0, '0, '0);
    rst = 1'b0;
    ticks(4);

    // Basic pair, trig1 two clocks after trig0
    trig0 = 1'b1;
    ticks(2);
    trig1 = 1'b1;
    wait_trig(8, lat);
    chk("t1_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    run_pulse(hi, bz);
    chk("t1_pulse_width", 64'(hi), 64'd8);
    chk("t1_busy_width", 64'(bz), 64'd33);
    chk_counts("t1", 1, 1, 1);

    // Window edge: 4 apart rejected, 3 apart accepted
    clear_counts();
    chk_counts("t2_clr", 0, 0, 0);
    trig0 = 1'b1;
    ticks(4);
    trig1 = 1'b1;
    wait_trig(10, lat);
    chk("t2_sep4_no_trig", 64'(lat), 64'(-1));
    set_both(1'b0);
    ticks(3);
    chk_counts("t2_sep4", 1, 1, 0);
    trig0 = 1'b1;
    ticks(3);
    trig1 = 1'b1;
    wait_trig(10, lat);
    chk("t2_sep3_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    run_pulse(hi, bz);
    chk("t2_sep3_width", 64'(hi), 64'd8);
    chk_counts("t2_sep3", 2, 2, 1);

    // Holdoff: pair 10 clk into holdoff rejected
    clear_counts();
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t3_first_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    to_pulse_end(hi);
    ticks(10);
    set_both(1'b1);
    wait_trig(6, lat);
    chk("t3_holdoff_no_trig", 64'(lat), 64'(-1));
    chk("t3_holdoff_busy", 64'(busy_o), 64'd1);
    set_both(1'b0);
    wait_idle("t3a", 60);
    chk_counts("t3a", 2, 2, 1);
    // Rises on last holdoff cycle are lost; rises on first idle cycle fire
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t3_second_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    to_pulse_end(hi);
    ticks(22);
    set_both(1'b1);
    wait_trig(6, lat);
    chk("t3_last_holdoff_no_trig", 64'(lat), 64'(-1));
    set_both(1'b0);
    ticks(4);
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t3_third_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    to_pulse_end(hi);
    ticks(23);
    set_both(1'b1);
    wait_trig(6, lat);
    chk("t3_first_idle_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    run_pulse(hi, bz);
    chk("t3_first_idle_width", 64'(hi), 64'd8);
    chk_counts("t3b", 6, 6, 4);

    // Enable gating
    clear_counts();
    en = 1'b0;
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t4_disabled_no_trig", 64'(lat), 64'(-1));
    chk("t4_disabled_busy", 64'(busy_o), 64'd0);
    set_both(1'b0);
    ticks(3);
    chk_counts("t4_disabled", 1, 1, 0);
    en = 1'b1;
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t4_latency", 64'(lat), 64'd3);
    en = 1'b0;
    set_both(1'b0);
    run_pulse(hi, bz);
    chk("t4_en_drop_width", 64'(hi), 64'd8);
    chk("t4_en_drop_busy", 64'(bz), 64'd33);
    en = 1'b1;
    chk_counts("t4", 2, 2, 1);

    // Saturation and clear priority
    force dut.trig0_cnt_q = ALL;
    force dut.trig1_cnt_q = ALL;
    force dut.coinc_cnt_q = ALL;
    tick();
    release dut.trig0_cnt_q;
    release dut.trig1_cnt_q;
    release dut.coinc_cnt_q;
    chk_counts("t5_preload", ALL, ALL, ALL);
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t5_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    run_pulse(hi, bz);
    chk_counts("t5_saturate", ALL, ALL, ALL);
    trig0 = 1'b1;
    ticks(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_counts("t5_clr_vs_rise", 0, 0, 0);
    trig0 = 1'b0;
    ticks(4);

    // Async reset mid-pulse
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t6_latency", 64'(lat), 64'd3);
    ticks(3);
    chk("t6_mid_fire", 64'(trig_o), 64'd1);
    #5 rst = 1'b1;
    #1;
    chk("t6_async_trig", 64'(trig_o), 64'd0);
    chk("t6_async_busy", 64'(busy_o), 64'd0);
    chk_counts("t6_async", 0, 0, 0);
    set_both(1'b0);
    ticks(2);
    rst = 1'b0;
    ticks(3);
    set_both(1'b1);
    wait_trig(8, lat);
    chk("t6_post_latency", 64'(lat), 64'd3);
    set_both(1'b0);
    run_pulse(hi, bz);
    chk("t6_post_width", 64'(hi), 64'd8);
    chk("t6_post_busy", 64'(bz), 64'd33);
    chk_counts("t6_post", 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
